// File: rtl/vm_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vm_pkg : opcodes, FSM encoding and helpers for the VM variable-arithmetic unit
// Rev 1.0
// ---------------------------------------------------------------------------
package vm_pkg;

  localparam logic [7:0] OP_MOV_CONST = 8'h00;
  localparam logic [7:0] OP_MOV       = 8'h01;
  localparam logic [7:0] OP_ADD       = 8'h02;
  localparam logic [7:0] OP_ADD_CONST = 8'h03;

  typedef logic [2:0] state_t;

  localparam state_t ST_CLEAR    = 3'd0;
  localparam state_t ST_IDLE     = 3'd1;
  localparam state_t ST_RD_ISSUE = 3'd2;
  localparam state_t ST_RD_WAIT  = 3'd3;
  localparam state_t ST_EXEC     = 3'd4;
  localparam state_t ST_FIN      = 3'd5;

  // Total instruction length in bytes, opcode byte included.
  function automatic logic [2:0] instr_len(input logic [7:0] op);
    case (op)
      OP_MOV, OP_ADD: instr_len = 3'd3;
      default:        instr_len = 3'd4;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/vm_var_file.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vm_var_file : VM variable storage, 1 sync write, 2 async reads, 1 registered debug read
// Rev 1.0
// ---------------------------------------------------------------------------
module vm_var_file
  import vm_pkg::*;
#(
  parameter int VAR_AW = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [VAR_AW-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [VAR_AW-1:0] dst_idx_i,
  output logic [DATA_W-1:0] dst_data_o,
  input  logic [VAR_AW-1:0] src_idx_i,
  output logic [DATA_W-1:0] src_data_o,
  input  logic [VAR_AW-1:0] dbg_idx_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  logic [DATA_W-1:0] mem_q [2**VAR_AW];
  logic [DATA_W-1:0] dbg_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign dst_data_o = mem_q[dst_idx_i];
  assign src_data_o = mem_q[src_idx_i];

  // Forward a same-cycle write so the debug port shows it one cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n)                            dbg_q <= '0;
    else if (we_i && waddr_i == dbg_idx_i) dbg_q <= wdata_i;
    else                                   dbg_q <= mem_q[dbg_idx_i];
  end

  assign dbg_data_o = dbg_q;

endmodule
`default_nettype wire

// File: rtl/vm_var_exec.sv
`default_nettype none
// ---------------------------------------------------------------------------
// vm_var_exec : byte-serial fetch and execute of movConst/mov/add/addConst
// Rev 1.0
// ---------------------------------------------------------------------------
module vm_var_exec
  import vm_pkg::*;
#(
  parameter int PC_W   = 16,
  parameter int VAR_AW = 8,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [PC_W-1:0]   start_pc,
  output logic              busy,
  output logic              done,
  output logic              illegal,
  output logic [PC_W-1:0]   next_pc,
  output logic              mem_rd_en,
  output logic [PC_W-1:0]   mem_addr,
  input  logic [7:0]        mem_rdata,
  input  logic [VAR_AW-1:0] dbg_idx,
  output logic [DATA_W-1:0] dbg_data
);

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d, next_pc_q, next_pc_d;
  logic [1:0]        k_q, k_d;
  logic [7:0]        op_q, op_d, dst_q, dst_d, b2_q, b2_d, b3_q, b3_d;
  logic [VAR_AW-1:0] clr_q, clr_d;

  logic              we;
  logic [VAR_AW-1:0] waddr;
  logic [DATA_W-1:0] wdata, rd_dst, rd_src, imm;
  logic [7:0]        cur_op;

  assign imm    = DATA_W'($signed({b2_q, b3_q}));
  assign cur_op = (k_q == 2'd0) ? mem_rdata : op_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    next_pc_d = next_pc_q;
    k_d       = k_q;
    op_d      = op_q;
    dst_d     = dst_q;
    b2_d      = b2_q;
    b3_d      = b3_q;
    clr_d     = clr_q;
    done      = 1'b0;
    illegal   = 1'b0;
    mem_rd_en = 1'b0;
    mem_addr  = '0;
    we        = 1'b0;
    waddr     = clr_q;
    wdata     = '0;
    case (state_q)
      ST_CLEAR: begin
        we    = 1'b1;
        clr_d = clr_q + VAR_AW'(1);
        if (clr_q == {VAR_AW{1'b1}}) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (start) begin
          pc_d    = start_pc;
          k_d     = 2'd0;
          state_d = ST_RD_ISSUE;
        end
      end
      ST_RD_ISSUE: begin
        mem_rd_en = 1'b1;
        mem_addr  = pc_q;
        pc_d      = pc_q + PC_W'(1);
        state_d   = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        case (k_q)
          2'd0:    op_d  = mem_rdata;
          2'd1:    dst_d = mem_rdata;
          2'd2:    b2_d  = mem_rdata;
          default: b3_d  = mem_rdata;
        endcase
        if (k_q == 2'd0 && mem_rdata > OP_ADD_CONST) begin
          done      = 1'b1;
          illegal   = 1'b1;
          next_pc_d = pc_q;
          state_d   = ST_FIN;
        end else if ({1'b0, k_q} == instr_len(cur_op) - 3'd1) begin
          state_d = ST_EXEC;
        end else begin
          k_d     = k_q + 2'd1;
          state_d = ST_RD_ISSUE;
        end
      end
      ST_EXEC: begin
        we        = 1'b1;
        waddr     = dst_q[VAR_AW-1:0];
        done      = 1'b1;
        next_pc_d = pc_q;
        state_d   = ST_FIN;
        case (op_q)
          OP_MOV_CONST: wdata = imm;
          OP_MOV:       wdata = rd_src;
          OP_ADD:       wdata = rd_dst + rd_src;
          default:      wdata = rd_dst + imm;
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
    // A reset cycle must neither commit a write nor signal completion.
    if (!rst_n) begin
      we      = 1'b0;
      done    = 1'b0;
      illegal = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_CLEAR;
      pc_q      <= '0;
      next_pc_q <= '0;
      k_q       <= '0;
      op_q      <= '0;
      dst_q     <= '0;
      b2_q      <= '0;
      b3_q      <= '0;
      clr_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      next_pc_q <= next_pc_d;
      k_q       <= k_d;
      op_q      <= op_d;
      dst_q     <= dst_d;
      b2_q      <= b2_d;
      b3_q      <= b3_d;
      clr_q     <= clr_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign next_pc = done ? pc_q : next_pc_q;

  vm_var_file #(
    .VAR_AW (VAR_AW),
    .DATA_W (DATA_W)
  ) u_var_file (
    .clk        (clk),
    .rst_n      (rst_n),
    .we_i       (we),
    .waddr_i    (waddr),
    .wdata_i    (wdata),
    .dst_idx_i  (dst_q[VAR_AW-1:0]),
    .dst_data_o (rd_dst),
    .src_idx_i  (b2_q[VAR_AW-1:0]),
    .src_data_o (rd_src),
    .dbg_idx_i  (dbg_idx),
    .dbg_data_o (dbg_data)
  );

endmodule
`default_nettype wire

// File: tb/tb_vm_var_exec.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_vm_var_exec : scoreboard bench for the VM variable-arithmetic unit
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_vm_var_exec;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] start_pc = '0;
  logic        busy, done, illegal, mem_rd_en;
  logic [15:0] next_pc, mem_addr;
  logic [7:0]  mem_rdata = '0;
  logic [7:0]  dbg_idx = '0;
  logic [15:0] dbg_data;

  always #5 clk = ~clk;

  vm_var_exec #(.PC_W(16), .VAR_AW(8), .DATA_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .start_pc  (start_pc),
    .busy      (busy),
    .done      (done),
    .illegal   (illegal),
    .next_pc   (next_pc),
    .mem_rd_en (mem_rd_en),
    .mem_addr  (mem_addr),
    .mem_rdata (mem_rdata),
    .dbg_idx   (dbg_idx),
    .dbg_data  (dbg_data)
  );

  logic [7:0]  bmem [0:65535];
  logic [15:0] rd_log [$];
  int          done_cnt = 0;

  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rdata <= bmem[mem_addr];
      rd_log.push_back(mem_addr);
    end
    if (done) done_cnt <= done_cnt + 1;
  end

  typedef struct {
    logic [15:0] npc;
    logic        ill;
    int          lat;
  } exp_t;
  exp_t sb [$];

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic chk_var(input string tag, input logic [7:0] idx, input logic [15:0] exp);
    @(negedge clk);
    dbg_idx = idx;
    @(posedge clk);
    #1;
    chk(tag, {16'h0, dbg_data}, {16'h0, exp});
  endtask

  // Loads the instruction bytes, queues the expected outcome, starts, and checks at done.
  task automatic run(input string tag, input logic [15:0] pc, input logic [31:0] bytes,
                     input int restart_at);
    exp_t        e;
    exp_t        got;
    int          nb;
    int          lat;
    logic [7:0]  op;
    logic [15:0] a;
    op    = bytes[31:24];
    e.ill = (op > 8'h03);
    nb    = e.ill ? 1 : ((op == 8'h01 || op == 8'h02) ? 3 : 4);
    for (int i = 0; i < nb; i++) begin
      a       = pc + 16'(i);
      bmem[a] = bytes[31-8*i -: 8];
    end
    e.npc = pc + 16'(nb);
    e.lat = e.ill ? 2 : 2 * nb + 1;
    sb.push_back(e);
    @(negedge clk);
    start_pc = pc;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      start = (lat == restart_at);
    end
    start    = 1'b0;
    got.npc  = next_pc;
    got.ill  = illegal;
    got.lat  = lat;
    e        = sb.pop_front();
    chk({tag, " done"}, {31'h0, done}, 32'h1);
    chk({tag, " latency"}, got.lat, e.lat);
    chk({tag, " next_pc"}, {16'h0, got.npc}, {16'h0, e.npc});
    chk({tag, " illegal"}, {31'h0, got.ill}, {31'h0, e.ill});
    repeat (2) @(posedge clk);
    #1;
    chk({tag, " idle"}, {31'h0, busy}, 32'h0);
  endtask

  task automatic wait_clear(input string tag);
    int cnt;
    cnt = 0;
    do begin
      @(posedge clk);
      #1;
      cnt++;
    end while (busy && cnt < 400);
    chk({tag, " clear cycles"}, cnt, 256);
  endtask

  initial begin
    int snap;
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", {31'h0, busy}, 32'h1);
    chk("rst done", {31'h0, done}, 32'h0);
    chk("rst illegal", {31'h0, illegal}, 32'h0);
    chk("rst next_pc", {16'h0, next_pc}, 32'h0);
    chk("rst mem_rd_en", {31'h0, mem_rd_en}, 32'h0);
    chk("rst mem_addr", {16'h0, mem_addr}, 32'h0);
    chk("rst dbg_data", {16'h0, dbg_data}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_clear("reset");
    chk_var("clr v00", 8'h00, 16'h0000);
    chk_var("clr v80", 8'h80, 16'h0000);
    chk_var("clr vFF", 8'hFF, 16'h0000);

    run("movc", 16'h0010, 32'h0005_1234, 0);
    chk_var("movc v5", 8'h05, 16'h1234);
    run("addc-2", 16'h0014, 32'h0305_FFFE, 0);
    chk_var("addc-2 v5", 8'h05, 16'h1232);
    run("movc1", 16'h0018, 32'h0005_0001, 0);
    run("addc-1", 16'h001C, 32'h0305_FFFF, 0);
    chk_var("addc wrap v5", 8'h05, 16'h0000);

    run("movc8000", 16'h0030, 32'h0001_8000, 0);
    run("movc8001", 16'h0034, 32'h0002_8001, 0);
    run("add", 16'h0038, 32'h0201_0200, 0);
    chk_var("add v1", 8'h01, 16'h0001);
    run("mov", 16'h003B, 32'h0107_0100, 0);
    chk_var("mov v7", 8'h07, 16'h0001);
    run("add self", 16'h003E, 32'h0207_0700, 0);
    chk_var("add self v7", 8'h07, 16'h0002);

    run("illegal", 16'h0020, 32'h2A00_0000, 0);
    chk_var("ill v1", 8'h01, 16'h0001);
    chk_var("ill v2", 8'h02, 16'h8001);
    chk_var("ill v7", 8'h07, 16'h0002);

    rd_log.delete();
    run("pc wrap", 16'hFFFE, 32'h0009_ABCD, 0);
    chk("wrap nreads", rd_log.size(), 4);
    if (rd_log.size() == 4) begin
      chk("wrap rd0", {16'h0, rd_log[0]}, 32'hFFFE);
      chk("wrap rd1", {16'h0, rd_log[1]}, 32'hFFFF);
      chk("wrap rd2", {16'h0, rd_log[2]}, 32'h0000);
      chk("wrap rd3", {16'h0, rd_log[3]}, 32'h0001);
    end
    chk_var("wrap v9", 8'h09, 16'hABCD);

    run("restart", 16'h0040, 32'h000A_1111, 3);
    snap = done_cnt;
    repeat (15) @(posedge clk);
    #1;
    chk("restart no extra done", done_cnt, snap);
    chk("restart idle", {31'h0, busy}, 32'h0);
    chk_var("restart vA", 8'h0A, 16'h1111);

    bmem[16'h0044] = 8'h00;
    bmem[16'h0045] = 8'h0B;
    bmem[16'h0046] = 8'h55;
    bmem[16'h0047] = 8'h55;
    snap = done_cnt;
    @(negedge clk);
    start_pc = 16'h0044;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_clear("mid reset");
    chk("mid reset no done", done_cnt, snap);
    chk_var("mid reset vB", 8'h0B, 16'h0000);
    chk_var("mid reset v5", 8'h05, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/vm_var_exec.md
Name: vm_var_exec

Overview:
- Execution unit for the Another World VM variable-arithmetic opcodes 0x00–0x03: movConst, mov, add, addConst.
- Fetches one instruction byte-serially from a bytecode read port and owns the VM variable file.
- Writes the result and reports the next PC.
- Sits beside the opcode dispatcher, which pulses start with a PC and waits for done.

Parameters:
- PC_W, 16, bytecode address width; PC arithmetic wraps modulo 2^PC_W.
- VAR_AW, 8, variable index width; NUM_VARS = 2^VAR_AW.
- DATA_W, 16, variable width; must be >= 16.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- start  in  1  execute one instruction at start_pc; honoured only when busy=0
- start_pc  in  PC_W  address of the opcode byte
- busy  out  1  high from reset-clear sweep or start acceptance until the cycle after done
- done  out  1  one-cycle pulse: instruction finished
- illegal  out  1  valid with done: opcode not in 0x00–0x03
- next_pc  out  PC_W  valid with done; held until the next done
- mem_rd_en  out  1  bytecode read strobe
- mem_addr  out  PC_W  bytecode byte address
- mem_rdata  in  8  read data; valid exactly 1 cycle after mem_rd_en
- dbg_idx  in  VAR_AW  debug variable select
- dbg_data  out  DATA_W  vmvar[dbg_idx], registered, 1-cycle latency

Behaviour:
- Reset values: busy=1, done=0, illegal=0, next_pc=0, mem_rd_en=0, mem_addr=0, dbg_data=0; FSM enters CLEAR.
- CLEAR: writes 0 to vmvar[0..NUM_VARS-1], one per cycle, then goes to IDLE (busy=0). NUM_VARS cycles.
- States: CLEAR, IDLE, RD_ISSUE, RD_WAIT, EXEC, FIN.
- IDLE + start: latch pc=start_pc, byte count k=0, busy=1.
- RD_ISSUE: mem_rd_en=1, mem_addr=pc, pc<=pc+1, go to RD_WAIT.
- RD_WAIT: capture mem_rdata into byte slot k.
  - k=0 is the opcode. If the opcode is >0x03: next_pc=pc, illegal=1, done=1, go to FIN.
  - Instruction length: 0x00 and 0x03 = 4 bytes (op, dst, immH, immL); 0x01 and 0x02 = 3 bytes (op, dst, src).
  - After the last byte go to EXEC, else back to RD_ISSUE.
- Operand encoding:
  - imm = {immH, immL}, big-endian, signed 16-bit, sign-extended to DATA_W.
  - dst/src byte low VAR_AW bits index the variable file; upper bits ignored.
- EXEC performs exactly one write, all arithmetic modulo 2^DATA_W:
  - movConst: vmvar[dst] = imm.
  - mov: vmvar[dst] = vmvar[src].
  - add: vmvar[dst] = vmvar[dst] + vmvar[src].
  - addConst: vmvar[dst] = vmvar[dst] + imm.
  - Same cycle: done=1, illegal=0, next_pc=pc. Go to FIN.
- FIN: done=0, busy=0, go to IDLE.
- Latency, with start sampled at cycle 0:
  - 4-byte op: done at cycle 9.
  - 3-byte op: done at cycle 7.
  - illegal opcode: done at cycle 2.
- Reads use the value before this instruction's write. For add with dst==src the result is 2x the old value.
- start while busy=1 (including during CLEAR) is ignored, not queued.
- PC wrap: bytes past 2^PC_W-1 are read from address 0; next_pc wraps the same way.
- Reset mid-operation: no write is performed and no done is produced; CLEAR re-runs.
- dbg_data reflects a write on the cycle after EXEC (read-after-write, 1-cycle latency).

Decomposition:
- Package vm_pkg:
  - OP_MOV_CONST=8'h00, OP_MOV=8'h01, OP_ADD=8'h02, OP_ADD_CONST=8'h03.
  - FSM state enum.
  - Function instr_len(op).
- Sub-module vm_var_file:
  - NUM_VARS x DATA_W.
  - One synchronous write port.
  - Two asynchronous read ports (dst, src).
  - One registered debug read port.

Test Plan:
- Reset release -> busy high for exactly 256 cycles; then dbg_data=0 for idx 0, 0x80, 0xFF.
- Bytes 00 05 12 34 at pc 0x10, start -> done at cycle 9, next_pc=0x14, vmvar[5]=0x1234, illegal=0.
- vmvar[5]=0x1234; bytes 03 05 FF FE (addConst -2) -> vmvar[5]=0x1232. Repeat from vmvar[5]=0x0001 with bytes 03 05 FF FF -> vmvar[5]=0x0000 (wrap).
- vmvar[1]=0x8000, vmvar[2]=0x8001; bytes 02 01 02 -> done at cycle 7, vmvar[1]=0x0001. Then bytes 01 07 01 -> vmvar[7]=0x0001. Then bytes 02 07 07 -> vmvar[7]=0x0002.
- Opcode 0x2A at pc 0x20 -> done+illegal at cycle 2, next_pc=0x21, no variable changed. movConst placed at pc 0xFFFE (PC_W=16) -> reads 0xFFFE, 0xFFFF, 0x0000, 0x0001; next_pc=0x0002.
- start pulsed again at cycle 3 -> ignored. rst_n low at cycle 5 of a movConst -> target variable stays 0 after CLEAR, and done never pulses.
